// File: rtl/opstage_pkg.sv
// Shared widths and the EX-stage register layout for the operand stage.
// Optional build macro: OPSTAGE_EX_BYPASS_EN (enables the EX-result bypass).
package opstage_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int HAZ_CNT_W  = 16;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '0;
endpackage

// File: rtl/operand_stage_if.sv
// Decode-slot, writeback, EX-feedback and control bundle for operand_stage.
interface operand_stage_if;
  import opstage_pkg::*;

  logic                  in_valid;
  logic [REG_ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic                  in_uses_rs1, in_uses_rs2, in_we, in_is_load;
  logic [XLEN-1:0]       in_pc, in_imm, rs1d, rs2d;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_we;
  logic [XLEN-1:0]       wb_data, ex_result;
  logic                  stall, flush;
  logic                  out_valid, out_we, out_is_load;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_op1, out_op2, out_pc, out_imm;
  logic                  hazard_stall;
  logic [HAZ_CNT_W-1:0]  hazard_count;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_we, in_is_load,
           in_pc, in_imm, rs1d, rs2d, wb_rd, wb_we, wb_data, ex_result, stall, flush,
    output out_valid, out_we, out_is_load, out_rd, out_op1, out_op2, out_pc, out_imm,
           hazard_stall, hazard_count
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_we, in_is_load,
           in_pc, in_imm, rs1d, rs2d, wb_rd, wb_we, wb_data, ex_result, stall, flush,
    input  out_valid, out_we, out_is_load, out_rd, out_op1, out_op2, out_pc, out_imm,
           hazard_stall, hazard_count
  );
endinterface

// File: rtl/operand_stage_fwd_mux.sv
// Per-source operand select: x0, then EX bypass, then WB bypass, then RegFile.
// The EX path is enabled by the caller through i_ex_fwd (OPSTAGE_EX_BYPASS_EN).
module fwd_mux
  import opstage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic                  i_ex_fwd,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]       i_ex_result,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_op
);
  always_comb begin
    o_op = i_rf_data;
    if (i_rs == '0)                         o_op = '0;
    else if (i_ex_fwd && i_ex_rd == i_rs)   o_op = i_ex_result;
    else if (i_wb_we && i_wb_rd == i_rs)    o_op = i_wb_data;
  end
endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: bypass select, load-use hazard bubble and EX-stage register.
// Build macro OPSTAGE_EX_BYPASS_EN: when undefined every EX-resident writer is a hazard.
module operand_stage
  import opstage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_stage_if.slave  bus
);
  ex_reg_t               r_ex;
  logic [HAZ_CNT_W-1:0]  r_hazard_count;

  logic [1:0][REG_ADDR_W-1:0] w_rs;
  logic [1:0]                 w_use;
  logic [1:0][XLEN-1:0]       w_rf;
  logic [1:0][XLEN-1:0]       w_op;
  logic [1:0]                 w_haz;
  logic                       w_ex_wr, w_ex_fwd, w_ex_blocks, w_hazard;

  assign w_rs    = {bus.in_rs2, bus.in_rs1};
  assign w_use   = {bus.in_uses_rs2, bus.in_uses_rs1};
  assign w_rf    = {bus.rs2d, bus.rs1d};
  assign w_ex_wr = r_ex.valid & r_ex.we;

`ifdef OPSTAGE_EX_BYPASS_EN
  assign w_ex_fwd    = w_ex_wr & ~r_ex.is_load;
  assign w_ex_blocks = r_ex.is_load;
`else
  assign w_ex_fwd    = 1'b0;
  assign w_ex_blocks = 1'b1;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_src
    fwd_mux u_fwd (
      .i_rs        (w_rs[g]),
      .i_rf_data   (w_rf[g]),
      .i_ex_fwd    (w_ex_fwd),
      .i_ex_rd     (r_ex.rd),
      .i_ex_result (bus.ex_result),
      .i_wb_we     (bus.wb_we),
      .i_wb_rd     (bus.wb_rd),
      .i_wb_data   (bus.wb_data),
      .o_op        (w_op[g])
    );
    assign w_haz[g] = bus.in_valid & w_use[g] & (w_rs[g] != '0) & w_ex_wr &
                      (r_ex.rd == w_rs[g]) & w_ex_blocks;
  end

  // Both sources hitting the same producer still cost a single bubble.
  assign w_hazard         = |w_haz;
  assign bus.hazard_stall = w_hazard & ~bus.flush & ~bus.stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex           <= EX_BUBBLE;
      r_hazard_count <= '0;
    end else if (bus.stall) begin
      r_ex           <= r_ex;
      r_hazard_count <= r_hazard_count;
    end else if (bus.flush || w_hazard) begin
      r_ex <= EX_BUBBLE;
      if (!bus.flush && r_hazard_count != '1)
        r_hazard_count <= r_hazard_count + 1'b1;
    end else begin
      r_ex <= '{valid: bus.in_valid, we: bus.in_we, is_load: bus.in_is_load,
                rd: bus.in_rd, op1: w_op[0], op2: w_op[1],
                pc: bus.in_pc, imm: bus.in_imm};
    end
  end

  assign bus.out_valid    = r_ex.valid;
  assign bus.out_we       = r_ex.we;
  assign bus.out_is_load  = r_ex.is_load;
  assign bus.out_rd       = r_ex.rd;
  assign bus.out_op1      = r_ex.op1;
  assign bus.out_op2      = r_ex.op2;
  assign bus.out_pc       = r_ex.pc;
  assign bus.out_imm      = r_ex.imm;
  assign bus.hazard_count = r_hazard_count;
endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus random traffic
// against a behavioural model. Honours OPSTAGE_EX_BYPASS_EN like the design.
module tb_operand_stage;
  import opstage_pkg::*;

`ifdef OPSTAGE_EX_BYPASS_EN
  localparam bit EX_EN = 1'b1;
`else
  localparam bit EX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  operand_stage_if bus ();
  operand_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // model of the EX-stage register and bubble counter
  logic        m_valid = 0, m_we = 0, m_load = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_op1 = 0, m_op2 = 0, m_pc = 0, m_imm = 0;
  logic [15:0] m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (EX_EN && m_valid && m_we && !m_load && m_rd == rs) return bus.ex_result;
    if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic src_hazard(input logic used, input logic [4:0] rs);
    return used && rs != 0 && bus.in_valid && m_valid && m_we && m_rd == rs &&
           (m_load || !EX_EN);
  endfunction

  function automatic logic model_hazard();
    return src_hazard(bus.in_uses_rs1, bus.in_rs1) || src_hazard(bus.in_uses_rs2, bus.in_rs2);
  endfunction

  task automatic model_edge();
    logic        h;
    logic [31:0] o1, o2;
    h  = model_hazard();
    o1 = pick(bus.in_rs1, bus.rs1d);
    o2 = pick(bus.in_rs2, bus.rs2d);
    if (!reset) begin
      {m_valid, m_we, m_load, m_rd} = '0;
      {m_op1, m_op2, m_pc, m_imm}   = '0;
      m_cnt = 0;
    end else if (bus.stall) begin
      // frozen
    end else if (bus.flush || h) begin
      {m_valid, m_we, m_load} = 3'b000;
      if (!bus.flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_valid = bus.in_valid; m_we = bus.in_we; m_load = bus.in_is_load;
      m_rd = bus.in_rd; m_op1 = o1; m_op2 = o2; m_pc = bus.in_pc; m_imm = bus.in_imm;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk("out_we", {31'b0, bus.out_we}, {31'b0, m_we});
    chk("out_is_load", {31'b0, bus.out_is_load}, {31'b0, m_load});
    chk("hazard_count", {16'b0, bus.hazard_count}, {16'b0, m_cnt});
    if (m_valid) begin
      chk("out_rd", {27'b0, bus.out_rd}, {27'b0, m_rd});
      chk("out_op1", bus.out_op1, m_op1);
      chk("out_op2", bus.out_op2, m_op2);
      chk("out_pc", bus.out_pc, m_pc);
      chk("out_imm", bus.out_imm, m_imm);
    end
  endtask

  // inputs are driven 1ns after a rising edge; step checks and advances one cycle
  task automatic step();
    #2;
    if (reset)
      chk("hazard_stall", {31'b0, bus.hazard_stall},
          {31'b0, model_hazard() && !bus.flush && !bus.stall});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_ins(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
    bus.in_valid = v; bus.in_rs1 = r1; bus.in_uses_rs1 = u1;
    bus.in_rs2 = r2; bus.in_uses_rs2 = u2; bus.in_rd = rd;
    bus.in_we = we; bus.in_is_load = ld;
    bus.in_pc = $urandom; bus.in_imm = $urandom;
    bus.rs1d = $urandom; bus.rs2d = $urandom; bus.ex_result = $urandom;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = $urandom;
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic set_rand();
    set_ins($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    bus.wb_we = 1'($urandom);
    bus.wb_rd = 5'($urandom_range(0, 7));
    bus.flush = $urandom_range(0, 9) == 0;
    bus.stall = $urandom_range(0, 7) == 0;
    reset     = $urandom_range(0, 49) != 0;
  endtask

  logic [15:0] cnt0;

  initial begin
    // reset held with a valid instruction presented
    reset = 1'b0;
    set_ins(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
    step(); step();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_op1", bus.out_op1, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("rst_cnt", {16'b0, bus.hazard_count}, 32'd0);
    reset = 1'b1;

    // EX bypass on a back-to-back ALU dependency
    set_ins(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); step();
    set_ins(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    bus.rs1d = 32'h0; bus.ex_result = 32'h0000_00AA;
    step();
    if (EX_EN) begin
      chk("exbyp_op1", bus.out_op1, 32'hAA);
      chk("exbyp_valid", {31'b0, bus.out_valid}, 32'd1);
    end else begin
      chk("exbyp_bubble", {31'b0, bus.out_valid}, 32'd0);
      bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_00AA;
      step();
      chk("exbyp_wb_op1", bus.out_op1, 32'hAA);
    end

    // WB bypass
    set_ins(1, 5'd0, 0, 5'd3, 1, 5'd8, 1, 0);
    bus.rs2d = 32'h0; bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h5555_5555;
    step();
    chk("wbbyp_op2", bus.out_op2, 32'h5555_5555);

    // load-use: one bubble then WB bypass
    set_ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); step();
    cnt0 = bus.hazard_count;
    set_ins(1, 5'd7, 1, 5'd7, 1, 5'd9, 1, 0);
    #2 chk("lu_hz", {31'b0, bus.hazard_stall}, 32'd1);
    #0; step();
    chk("lu_bubble", {31'b0, bus.out_valid}, 32'd0);
    chk("lu_cnt", {16'b0, bus.hazard_count}, {16'b0, cnt0 + 16'd1});
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hCAFE_F00D;
    step();
    chk("lu_wb_op1", bus.out_op1, 32'hCAFE_F00D);
    chk("lu_wb_op2", bus.out_op2, 32'hCAFE_F00D);

    // flush beats hazard
    set_ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); step();
    cnt0 = bus.hazard_count;
    set_ins(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0); bus.flush = 1'b1;
    step();
    chk("flush_bubble", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_cnt", {16'b0, bus.hazard_count}, {16'b0, cnt0});

    // stall beats hazard
    set_ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); step();
    set_ins(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0); bus.stall = 1'b1;
    step();
    chk("stall_held_ld", {31'b0, bus.out_is_load}, 32'd1);
    chk("stall_held_rd", {27'b0, bus.out_rd}, 32'd7);

    // x0 never forwards
    set_ins(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    step();
    chk("x0_op1", bus.out_op1, 32'd0);
    chk("x0_op2", bus.out_op2, 32'd0);

    // reset in the middle of a stalled hazard
    set_ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); step();
    set_ins(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0); bus.stall = 1'b1; reset = 1'b0;
    step();
    chk("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_mid_cnt", {16'b0, bus.hazard_count}, 32'd0);
    reset = 1'b1;
    set_ins(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 0);
    step();
    chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);

    // preload the counter near its ceiling, then drive load-use pairs
    force dut.r_hazard_count = 16'hFFFD;
    #1 release dut.r_hazard_count;
    m_cnt = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      set_ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); step();
      set_ins(1, 5'd7, 1, 5'd7, 1, 5'd9, 1, 0); step();
    end
    chk("sat_cnt", {16'b0, bus.hazard_count}, 32'h0000_FFFF);

    for (int i = 0; i < 600; i++) begin
      set_rand();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
